// File: rtl/calc_pkg.sv
// Shared constants for the calculator entry path.
// Key codes, FSM state encodings and ALU opcodes.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_NEG = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd13;
    localparam logic [3:0] KEY_CLR = 4'd14;
    localparam logic [3:0] KEY_RSV = 4'd15;

    typedef enum logic [1:0] {
        ST_RESULT  = 2'b00,
        ST_ENTRY_A = 2'b01,
        ST_ENTRY_B = 2'b10,
        ST_COMPUTE = 2'b11
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/digit_entry_buffer.sv
// Three-digit BCD shift register with digit count and sign flag.
// loadFirst beats clear; clear leaves the sign equal to toggleSign.
module digit_entry_buffer
    import calc_pkg::*;
(
    input  logic       Clock,
    input  logic       reset,
    input  logic       shiftIn,
    input  logic       toggleSign,
    input  logic       clear,
    input  logic       loadFirst,
    input  logic [3:0] keyDigit,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [1:0] count,
    output logic       isNegative
);

    // Digit shift, saturating count and sign toggle.
    always_ff @(posedge Clock) begin
        if (reset) begin
            digit1     <= 4'd0;
            digit2     <= 4'd0;
            digit3     <= 4'd0;
            count      <= 2'd0;
            isNegative <= 1'b0;
        end else if (loadFirst) begin
            digit1     <= keyDigit;
            digit2     <= 4'd0;
            digit3     <= 4'd0;
            count      <= 2'd1;
            isNegative <= 1'b0;
        end else if (clear) begin
            digit1     <= 4'd0;
            digit2     <= 4'd0;
            digit3     <= 4'd0;
            count      <= 2'd0;
            isNegative <= toggleSign;
        end else begin
            if (shiftIn && count != 2'd3) begin
                digit3 <= digit2;
                digit2 <= digit1;
                digit1 <= keyDigit;
                count  <= count + 2'd1;
            end
            if (toggleSign) begin
                isNegative <= ~isNegative;
            end
        end
    end

endmodule

// File: rtl/calc_entry_controller.sv
// Keypad sequencer: digit/sign/operator entry, ALU start and watchdog.
// The state register drives stateEncoder directly.
module calc_entry_controller
    import calc_pkg::*;
#(
    parameter int ALU_TIMEOUT = 255
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       keyValid,
    input  logic [3:0] keyCode,
    input  logic       aluDone,
    output logic [1:0] stateEncoder,
    output logic       isNegative,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       opcode,
    output logic       aluStart,
    output logic       resultValid,
    output logic       aluError
);

    localparam int WD_W = (ALU_TIMEOUT > 0) ? $clog2(ALU_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ALU_TIMEOUT);

    state_t          state;
    logic [WD_W-1:0] watchdog;
    logic [1:0]      count;

    logic key_digit;
    logic key_op;
    logic key_neg;
    logic key_eq;
    logic key_clr;
    logic in_entry;
    logic op_val;

    logic shift_in;
    logic toggle_sign;
    logic clear_buf;
    logic load_first;

    assign stateEncoder = state;

    // Key decode and digit-buffer control from the current state.
    always_comb begin
        key_digit = keyValid && is_digit(keyCode);
        key_op    = keyValid && (keyCode == KEY_ADD || keyCode == KEY_SUB);
        key_neg   = keyValid && (keyCode == KEY_NEG);
        key_eq    = keyValid && (keyCode == KEY_EQ);
        key_clr   = keyValid && (keyCode == KEY_CLR);
        op_val    = (keyCode == KEY_SUB) ? OP_SUB : OP_ADD;
        in_entry  = (state == ST_ENTRY_A) || (state == ST_ENTRY_B);

        shift_in    = in_entry && key_digit;
        toggle_sign = key_neg && (in_entry || state == ST_RESULT);
        clear_buf   = (in_entry && key_clr)
                    || (state == ST_ENTRY_A && key_op)
                    || (state == ST_RESULT && key_neg);
        load_first  = (state == ST_RESULT) && key_digit;
    end

    digit_entry_buffer u_buf (
        .Clock      (Clock),
        .reset      (reset),
        .shiftIn    (shift_in),
        .toggleSign (toggle_sign),
        .clear      (clear_buf),
        .loadFirst  (load_first),
        .keyDigit   (keyCode),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .count      (count),
        .isNegative (isNegative)
    );

    // Entry FSM with opcode register, ALU start pulse and watchdog.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state       <= ST_ENTRY_A;
            opcode      <= OP_ADD;
            aluStart    <= 1'b0;
            resultValid <= 1'b0;
            aluError    <= 1'b0;
            watchdog    <= '0;
        end else begin
            aluStart <= 1'b0;
            case (state)
                ST_ENTRY_A: begin
                    if (key_op) begin
                        opcode <= op_val;
                        state  <= ST_ENTRY_B;
                    end
                end
                ST_ENTRY_B: begin
                    if (key_op) begin
                        if (count == 2'd0) begin
                            opcode <= op_val;
                        end
                    end else if (key_eq) begin
                        state    <= ST_COMPUTE;
                        aluStart <= 1'b1;
                        watchdog <= '0;
                    end
                end
                ST_COMPUTE: begin
                    // aluDone is ignored while the start pulse is out.
                    if (aluDone && !aluStart) begin
                        state       <= ST_RESULT;
                        resultValid <= 1'b1;
                        watchdog    <= '0;
                    end else if (watchdog == WD_LAST) begin
                        state       <= ST_RESULT;
                        resultValid <= 1'b1;
                        aluError    <= 1'b1;
                        watchdog    <= '0;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (key_digit || key_neg) begin
                        state       <= ST_ENTRY_A;
                        resultValid <= 1'b0;
                        aluError    <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_ENTRY_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_controller.sv
// Bench for calc_entry_controller: directed plan plus random keys,
// checked every cycle against a value-level reference model.
module tb_calc_entry_controller;

    localparam int TO = 4;

    logic       Clock;
    logic       reset;
    logic       keyValid;
    logic [3:0] keyCode;
    logic       aluDone;
    logic [1:0] stateEncoder;
    logic       isNegative;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       opcode;
    logic       aluStart;
    logic       resultValid;
    logic       aluError;

    calc_entry_controller #(.ALU_TIMEOUT(TO)) dut (
        .Clock        (Clock),
        .reset        (reset),
        .keyValid     (keyValid),
        .keyCode      (keyCode),
        .aluDone      (aluDone),
        .stateEncoder (stateEncoder),
        .isNegative   (isNegative),
        .digit1       (digit1),
        .digit2       (digit2),
        .digit3       (digit3),
        .opcode       (opcode),
        .aluStart     (aluStart),
        .resultValid  (resultValid),
        .aluError     (aluError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    // Model: state code, operand as decimal value with digit count.
    int m_st;
    int m_val;
    int m_cnt;
    int m_cyc;
    bit m_neg;
    bit m_op;
    bit m_start;
    bit m_rv;
    bit m_err;

    // Operand register downstream, loads while in ENTRY_A.
    logic [12:0] opA;
    always @(posedge Clock)
        if (stateEncoder == 2'b01)
            opA <= {isNegative, digit3, digit2, digit1};

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v,
                              input int c, input bit d);
        m_start = 0;
        if (r) begin
            m_st = 1; m_val = 0; m_cnt = 0; m_neg = 0;
            m_op = 0; m_rv = 0; m_err = 0; m_cyc = 0;
        end else if (m_st == 1 || m_st == 2) begin
            if (v && c <= 9) begin
                if (m_cnt < 3) begin
                    m_val = m_val * 10 + c;
                    m_cnt++;
                end
            end else if (v && c == 12) begin
                m_neg = !m_neg;
            end else if (v && c == 14) begin
                m_val = 0; m_cnt = 0; m_neg = 0;
            end else if (v && (c == 10 || c == 11)) begin
                if (m_st == 1) begin
                    m_op = (c == 11);
                    m_st = 2;
                    m_val = 0; m_cnt = 0; m_neg = 0;
                end else if (m_cnt == 0) begin
                    m_op = (c == 11);
                end
            end else if (v && c == 13 && m_st == 2) begin
                m_st = 3; m_start = 1; m_cyc = 0;
            end
        end else if (m_st == 3) begin
            if (d && m_cyc > 0) begin
                m_st = 0; m_rv = 1;
            end else if (m_cyc == TO) begin
                m_st = 0; m_rv = 1; m_err = 1;
            end else begin
                m_cyc++;
            end
        end else begin
            if (v && c <= 9) begin
                m_st = 1; m_val = c; m_cnt = 1; m_neg = 0;
                m_rv = 0; m_err = 0;
            end else if (v && c == 12) begin
                m_st = 1; m_val = 0; m_cnt = 0; m_neg = 1;
                m_rv = 0; m_err = 0;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock) begin
        if (chk_en) begin
            cmp("state", stateEncoder, m_st);
            cmp("digit1", digit1, m_val % 10);
            cmp("digit2", digit2, (m_val / 10) % 10);
            cmp("digit3", digit3, m_val / 100);
            cmp("isNegative", isNegative, m_neg);
            cmp("opcode", opcode, m_op);
            cmp("aluStart", aluStart, m_start);
            cmp("resultValid", resultValid, m_rv);
            cmp("aluError", aluError, m_err);
        end
    end

    task automatic tick(input bit r, input bit v,
                        input logic [3:0] c, input bit d);
        reset = r; keyValid = v; keyCode = c; aluDone = d;
        @(posedge Clock);
        model_step(r, v, int'(c), d);
        #1;
    endtask

    task automatic key(input logic [3:0] c);
        tick(0, 1, c, 0);
    endtask

    task automatic idle(input bit d);
        tick(0, 0, 4'd0, d);
    endtask

    initial begin
        reset = 1; keyValid = 0; keyCode = 0; aluDone = 0;
        tick(1, 0, 0, 0);
        chk_en = 1;
        cmp("rst_state", stateEncoder, 1);
        cmp("rst_digits", {digit3, digit2, digit1}, 0);
        cmp("rst_flags", {isNegative, opcode, aluStart, resultValid, aluError}, 0);

        key(1); key(2); key(3);
        cmp("d123", {digit3, digit2, digit1}, 12'h123);
        key(9);
        cmp("d123_sat", {digit3, digit2, digit1}, 12'h123);

        key(14);
        cmp("clr", {digit3, digit2, digit1}, 0);
        key(7); key(12); key(10);
        cmp("add_state", stateEncoder, 2);
        cmp("add_digits", {digit3, digit2, digit1}, 0);
        cmp("add_neg", isNegative, 0);
        cmp("add_op", opcode, 0);
        cmp("opA_capture", opA, 13'h1007);

        key(11);
        cmp("opB_sub", opcode, 1);
        key(10); key(4); key(5); key(11);
        cmp("opB_final", opcode, 0);
        cmp("b_digits", {digit3, digit2, digit1}, 12'h045);

        key(13);
        cmp("start_pulse", aluStart, 1);
        cmp("compute_state", stateEncoder, 3);
        idle(0);
        cmp("start_once", aluStart, 0);
        idle(0); idle(0); idle(1);
        cmp("res_state", stateEncoder, 0);
        cmp("res_valid", resultValid, 1);
        cmp("res_noerr", aluError, 0);
        key(6);
        cmp("res_to_a", stateEncoder, 1);
        cmp("res_digit", {digit3, digit2, digit1}, 12'h006);

        key(10); key(13);
        for (int i = 0; i < TO; i++) idle(0);
        cmp("wd_wait", stateEncoder, 3);
        idle(0);
        cmp("wd_state", stateEncoder, 0);
        cmp("wd_err", aluError, 1);
        key(3);
        cmp("err_clr", aluError, 0);

        key(10); key(13);
        for (int i = 0; i < TO; i++) idle(0);
        idle(1);
        cmp("tie_state", stateEncoder, 0);
        cmp("tie_err", aluError, 0);

        key(2); key(10); key(13);
        idle(1);
        cmp("done_w_start", stateEncoder, 3);
        tick(1, 0, 0, 1);
        cmp("midrst_state", stateEncoder, 1);
        cmp("midrst_digits", {digit3, digit2, digit1}, 0);
        cmp("midrst_flags", {isNegative, opcode, aluStart, resultValid, aluError}, 0);

        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit v;
            bit d;
            logic [3:0] c;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 5) == 0);
            c = 4'($urandom_range(0, 15));
            tick(r, v, c, d);
        end
        idle(0);
        @(negedge Clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_entry_controller.md
# calc_entry_controller

Keypad sequencer for the calculator datapath. Turns one-cycle key events into BCD digit, sign and operator values. Drives the 2-bit `stateEncoder` that tells the operand registers when to capture. Starts the ALU and waits for it with a watchdog. Sits between the keypad decoder and the operand_1 and operand_2 registers and the ALU.

## Interface
Parameters:
- `ALU_TIMEOUT`, default 255: maximum cycles in COMPUTE waiting for `aluDone` before an error is declared.

Ports:
- `Clock`  in  1  system clock; all logic rises on posedge.
- `reset`  in  1  synchronous, active-high; clears the whole controller.
- `keyValid`  in  1  one-cycle pulse; `keyCode` is valid this cycle.
- `keyCode`  in  4  0–9 = digit; 10 = ADD; 11 = SUB; 12 = NEG; 13 = EQUALS; 14 = CLEAR_ENTRY; 15 = reserved.
- `aluDone`  in  1  ALU result ready; pulse or level, sampled only in COMPUTE.
- `stateEncoder`  out  2  00 = RESULT, 01 = ENTRY_A, 10 = ENTRY_B, 11 = COMPUTE.
- `isNegative`  out  1  sign of the operand currently being entered.
- `digit1`, `digit2`, `digit3`  out  4 each  BCD digits; `digit1` is least significant.
- `opcode`  out  1  0 = add, 1 = subtract; held from operator entry until the next entry.
- `aluStart`  out  1  one-cycle pulse on entry to COMPUTE.
- `resultValid`  out  1  high throughout RESULT.
- `aluError`  out  1  set on watchdog expiry; cleared on the next entry into ENTRY_A.

## Operation
- Registered Moore FSM with states ENTRY_A, ENTRY_B, COMPUTE and RESULT, encoded exactly as `stateEncoder`.
- **Digit key, ENTRY_A or ENTRY_B:**
  - If `count` < 3: shift `digit3<=digit2`, `digit2<=digit1`, `digit1<=key`, and `count++`.
  - If `count` = 3: ignore the key; no wrap.
  - Zero is a normal digit.
- **NEG key, ENTRY_A or ENTRY_B:** toggle `isNegative`.
- **CLEAR_ENTRY key, ENTRY_A or ENTRY_B:** zero the digits, `count` and `isNegative`; state is unchanged.
- **ENTRY_A:**
  - ADD/SUB: latch `opcode`, go to ENTRY_B, and clear the digits, `count` and sign on the same edge.
  - EQUALS: ignored.
- **ENTRY_B:**
  - ADD/SUB with `count` = 0: replace `opcode`.
  - ADD/SUB with `count` > 0: ignored.
  - EQUALS: go to COMPUTE; the digits are held.
- **COMPUTE:**
  - All keys are ignored.
  - `aluDone` → RESULT.
  - Watchdog reaches `ALU_TIMEOUT` → RESULT with `aluError` = 1.
  - If `aluDone` and watchdog expiry occur in the same cycle, `aluDone` wins and `aluError` stays 0.
- **RESULT:**
  - Digit key: go to ENTRY_A with `digit1` = key, other digits 0, `count` = 1, sign 0.
  - NEG key: go to ENTRY_A with digits 0 and sign 1.
  - ADD/SUB, EQUALS and CLEAR_ENTRY: ignored.
  - Either transition to ENTRY_A clears `aluError`.
- Reserved code 15 is ignored in every state.
- **Reset (any state, including mid-COMPUTE):** `stateEncoder`=01, digits=0, `count`=0, `isNegative`=0, `opcode`=0, `aluStart`=0, `resultValid`=0, `aluError`=0, watchdog=0.

## Timing
- Key effects are visible one cycle after the `keyValid` cycle.
- `stateEncoder` changes on the same edge that clears the digits. A downstream register loading while `stateEncoder`=01 therefore samples the final ENTRY_A digits on the transition edge and then holds.
- `aluStart` is high for exactly the first cycle of COMPUTE.
- Watchdog:
  - Width is clog2(`ALU_TIMEOUT`+1).
  - Counts from 0 starting in the first COMPUTE cycle.
  - Expiry is the cycle in which the count equals `ALU_TIMEOUT`.
  - Cleared on leaving COMPUTE.
- `aluDone` is sampled from the second COMPUTE cycle onward. An `aluDone` coincident with `aluStart` is ignored.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `calc_pkg` holds:
  - key code constants (`KEY_ADD`=10 … `KEY_CLR`=14);
  - state encodings (`ST_RESULT`, `ST_ENTRY_A`, `ST_ENTRY_B`, `ST_COMPUTE`);
  - opcode constants (`OP_ADD`, `OP_SUB`).
- One sub-module, `digit_entry_buffer`:
  - contains the 3-digit shift register, 2-bit `count` and sign flip-flop;
  - controls: `shiftIn`, `toggleSign`, `clear`, `loadFirst`.
- The FSM, opcode register and watchdog live in the top level.

## Test plan
- Reset, then keys 1, 2, 3 → `digit3..1` = 1,2,3; `stateEncoder`=01; a 4th key 9 leaves 1,2,3.
- Key 7, NEG, ADD → on the ADD+1 cycle `stateEncoder`=10, digits 0, `isNegative`=0, `opcode`=0; a registered operand captured with `stateEncoder`=01 holds the signed value 7 with its sign bit set.
- In ENTRY_B: SUB, then ADD, then 4, 5, then SUB → `opcode`=0 (the last SUB is ignored because `count`>0); digits 0,4,5.
- EQUALS in ENTRY_B → `aluStart` pulses once; `aluDone` 3 cycles later → `stateEncoder`=00, `resultValid`=1; key 6 → ENTRY_A with `digit1`=6.
- `ALU_TIMEOUT`=4 and `aluDone` never asserted → RESULT with `aluError`=1; a repeat run with `aluDone` on the expiry cycle → `aluError`=0.
- `reset` asserted mid-COMPUTE with `aluDone` high → next cycle all outputs at reset values and `stateEncoder`=01.
